// File: rtl/arith_right_shift_seq_pkg.sv
// Shared types and sizes for the negedge sequential arithmetic right shifter.
// Optional feature macro used by this block: ARSR_STICKY_EN.
package arith_shift_pkg;

  localparam int ARSR_WIDTH = 128;
  localparam int ARSR_AMT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } arsr_state_e;

endpackage : arith_shift_pkg

// File: rtl/arith_right_shift_seq_if.sv
// Operand/result bundle of arith_right_shift_seq; the sticky signal exists
// only when ARSR_STICKY_EN is defined.
interface arith_right_shift_seq_if
  import arith_shift_pkg::*;
#(
  parameter int WIDTH = ARSR_WIDTH,
  parameter int AMT_W = ARSR_AMT_W
);

  logic             start;
  logic [WIDTH-1:0] d;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
`ifdef ARSR_STICKY_EN
  logic             sticky;
`endif

  modport master (
    output start, d, amt,
`ifdef ARSR_STICKY_EN
    input  sticky,
`endif
    input  q, busy, done
  );

  modport slave (
    input  start, d, amt,
`ifdef ARSR_STICKY_EN
    output sticky,
`endif
    output q, busy, done
  );

endinterface : arith_right_shift_seq_if

// File: rtl/arith_right_shift_seq_shift_count_down.sv
// Loadable down-counter on the falling edge; term_o flags the last shift (cnt==1).
module shift_count_down #(
  parameter int W = 7
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(negedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == W'(1));

endmodule : shift_count_down

// File: rtl/arith_right_shift_seq.sv
// Negedge sequential arithmetic right shifter: one sign-extending shift per cycle.
// ARSR_STICKY_EN adds a sticky register/port ORing all shifted-out bits.
module arith_right_shift_seq
  import arith_shift_pkg::*;
#(
  parameter int WIDTH = ARSR_WIDTH,
  parameter int AMT_W = ARSR_AMT_W
) (
  input  logic                    clock,
  input  logic                    reset,
  arith_right_shift_seq_if.slave  bus
);

  arsr_state_e      state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_term;

  shift_count_down #(.W(AMT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (bus.amt),
    .dec_i      (cnt_dec),
    .term_o     (cnt_term)
  );

`ifdef ARSR_STICKY_EN
  logic sticky_q, sticky_d;
`else
  logic unused_lsb;
  assign unused_lsb = q_q[0];
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef ARSR_STICKY_EN
    sticky_d = sticky_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          q_d      = bus.d;
          cnt_load = 1'b1;
`ifdef ARSR_STICKY_EN
          sticky_d = 1'b0;
`endif
          state_d  = (bus.amt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        cnt_dec = 1'b1;
`ifdef ARSR_STICKY_EN
        sticky_d = sticky_q | q_q[0];
`endif
        // cnt==1 means this edge performs the final shift.
        if (cnt_term) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
`ifdef ARSR_STICKY_EN
      sticky_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
`ifdef ARSR_STICKY_EN
      sticky_q <= sticky_d;
`endif
    end
  end

  assign bus.q    = q_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
`ifdef ARSR_STICKY_EN
  assign bus.sticky = sticky_q;
`endif

endmodule : arith_right_shift_seq
